// File: rtl/niosii_sysid_pkg.sv
// Shared types and address map for the Nios II sysid checker.
// State encoding and the two sysid control-slave word addresses.
package niosii_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_RD_TS,
        ST_CMP,
        ST_DONE,
        ST_FAIL
    } sysid_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // States in which a new check may be launched.
    function automatic logic is_rest_state(input sysid_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAIL);
    endfunction

endpackage

// File: rtl/niosii_sysid_timer.sv
// Per-attempt stall counter and per-word retry counter.
// timeout is combinational so the read strobe drops right after the last allowed stall.
module niosii_sysid_timer
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned RETRY_LIMIT    = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    input  logic retry_clear,
    output logic timeout,
    output logic retries_exhausted
);
    import niosii_sysid_pkg::*;

    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] LP_RETRY_MAX = 3'(RETRY_LIMIT);

    logic [7:0] r_wait_cnt;
    logic [2:0] r_retry_cnt;

    assign timeout           = stall && (r_wait_cnt == LP_WAIT_LAST);
    assign retries_exhausted = (r_retry_cnt == LP_RETRY_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_retry_cnt <= '0;
        end else begin
            if (clear || timeout) begin
                r_wait_cnt <= '0;
            end else if (stall) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (retry_clear) begin
                r_retry_cnt <= '0;
            end else if (timeout && !retries_exhausted) begin
                r_retry_cnt <= r_retry_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/niosii_sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them
// against the values this image was built with, retrying on stalls.
module niosii_sysid_checker
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1488227433,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned RETRY_LIMIT    = 2,
    parameter int unsigned AUTO_START     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
    import niosii_sysid_pkg::*;

    sysid_state_t r_state;
    logic         r_auto;
    logic         r_read;
    logic         r_addr;
    logic         r_busy;
    logic         r_done;
    logic         r_id_ok;
    logic         r_ts_ok;
    logic         r_terr;
    logic [31:0]  r_id_value;
    logic [31:0]  r_ts_value;

    logic w_stall;
    logic w_complete;
    logic w_go;
    logic w_enter_rd;
    logic w_timeout;
    logic w_exhausted;

    assign w_stall    = r_read & avm_waitrequest;
    assign w_complete = r_read & ~avm_waitrequest;
    assign w_go       = is_rest_state(r_state) & (start | r_auto);
    assign w_enter_rd = w_go | ((r_state == ST_RD_ID) & w_complete);

    niosii_sysid_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .RETRY_LIMIT    (RETRY_LIMIT)
    ) u_timer (
        .clock             (clock),
        .reset             (reset),
        .clear             (w_enter_rd | w_complete),
        .stall             (w_stall),
        .retry_clear       (w_enter_rd),
        .timeout           (w_timeout),
        .retries_exhausted (w_exhausted)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_auto     <= (AUTO_START != 0);
            r_read     <= 1'b0;
            r_addr     <= SYSID_ADDR_ID;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_terr     <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
        end else begin
            r_auto <= 1'b0;
            unique case (r_state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (w_go) begin
                        r_state <= ST_RD_ID;
                        r_addr  <= SYSID_ADDR_ID;
                        r_read  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_terr  <= 1'b0;
                        r_id_ok <= 1'b0;
                        r_ts_ok <= 1'b0;
                    end
                end
                ST_RD_ID: begin
                    if (w_complete) begin
                        r_id_value <= avm_readdata;
                        r_state    <= ST_RD_TS;
                        r_addr     <= SYSID_ADDR_TS;
                        r_read     <= 1'b1;
                    end else if (w_timeout && w_exhausted) begin
                        r_state <= ST_FAIL;
                        r_read  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_terr  <= 1'b1;
                    end else begin
                        // A timeout leaves a one-cycle gap before re-issuing.
                        r_read <= ~w_timeout;
                    end
                end
                ST_RD_TS: begin
                    if (w_complete) begin
                        r_ts_value <= avm_readdata;
                        r_state    <= ST_CMP;
                        r_read     <= 1'b0;
                    end else if (w_timeout && w_exhausted) begin
                        r_state <= ST_FAIL;
                        r_read  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_terr  <= 1'b1;
                    end else begin
                        r_read <= ~w_timeout;
                    end
                end
                ST_CMP: begin
                    r_id_ok <= (r_id_value == EXPECTED_ID);
                    r_ts_ok <= (r_ts_value == EXPECTED_TS);
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign avm_address = r_addr;
    assign avm_read    = r_read;
    assign busy        = r_busy;
    assign done        = r_done;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout_err = r_terr;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_niosii_sysid_checker.sv
// Randomized bench for niosii_sysid_checker: a stalling sysid slave plus
// an attempt-level latency/result model.
module tb_niosii_sysid_checker;

    localparam logic [31:0] TB_EXP_ID  = 32'd0;
    localparam logic [31:0] TB_EXP_TS  = 32'd1488227433;
    localparam int          TB_TO      = 16;
    localparam int          TB_RETRIES = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout_err;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int n_checks = 0;
    int n_errors = 0;

    // Slave plan: stall cycles per attempt for each word (>= TB_TO means stuck).
    int          plan_id[TB_RETRIES+1];
    int          plan_ts[TB_RETRIES+1];
    logic [31:0] d_id = '0;
    logic [31:0] d_ts = '0;
    int          epoch = 0;

    logic [31:0] m_id_val = '0;
    logic [31:0] m_ts_val = '0;

    niosii_sysid_checker #(
        .EXPECTED_ID    (TB_EXP_ID),
        .EXPECTED_TS    (TB_EXP_TS),
        .TIMEOUT_CYCLES (TB_TO),
        .RETRY_LIMIT    (TB_RETRIES),
        .AUTO_START     (1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout_err     (timeout_err),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    always #5 clock = ~clock;

    int   att_id = 0;
    int   att_ts = 0;
    int   s_cnt = 0;
    int   seen_epoch = 0;
    int   cur_plan;
    logic s_last_wr = 1'b0;
    logic s_last_addr = 1'b0;

    always @(negedge clock) begin
        if (seen_epoch != epoch) begin
            att_id = 0;
            att_ts = 0;
            s_cnt = 0;
            seen_epoch = epoch;
        end
        if (avm_read !== 1'b1) begin
            if (s_last_wr) begin
                if (s_last_addr) att_ts++;
                else att_id++;
            end
            s_cnt = 0;
            avm_waitrequest = 1'b0;
        end else begin
            if (avm_address)
                cur_plan = (att_ts <= TB_RETRIES) ? plan_ts[att_ts] : 0;
            else
                cur_plan = (att_id <= TB_RETRIES) ? plan_id[att_id] : 0;
            if (s_cnt < cur_plan) begin
                avm_waitrequest = 1'b1;
                s_cnt++;
            end else begin
                avm_waitrequest = 1'b0;
                s_cnt = 0;
            end
        end
        avm_readdata = avm_waitrequest ? $urandom :
                       (avm_address ? d_ts : d_id);
        s_last_wr = (avm_read === 1'b1) && avm_waitrequest;
        s_last_addr = avm_address;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycles a word spends in its read state; ok=0 when every attempt is stuck.
    function automatic int word_cycles(input int a0, input int a1,
                                       input int a2, output bit ok);
        int s[3];
        int c;
        s[0] = a0;
        s[1] = a1;
        s[2] = a2;
        c = 0;
        ok = 1'b0;
        for (int i = 0; i <= TB_RETRIES; i++) begin
            if (s[i] < TB_TO) begin
                ok = 1'b1;
                return c + s[i] + 1;
            end
            c += TB_TO + 1;
        end
        return c - 1;
    endfunction

    function automatic int rnd_stall();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 2) return TB_TO + int'($urandom_range(0, 4));
        if (r == 2) return TB_TO - 1;
        return int'($urandom_range(0, 4));
    endfunction

    task automatic run_check(input bit auto_go, input bit mid_start);
        bit   ok_id;
        bit   ok_ts;
        bit   exp_fail;
        int   c_id;
        int   c_ts;
        int   lat;
        int   cyc;
        int   stalls;
        logic p_stall;
        logic p_addr;
        c_id = word_cycles(plan_id[0], plan_id[1], plan_id[2], ok_id);
        c_ts = word_cycles(plan_ts[0], plan_ts[1], plan_ts[2], ok_ts);
        if (!ok_id) begin
            exp_fail = 1'b1;
            lat = c_id + 1;
        end else if (!ok_ts) begin
            exp_fail = 1'b1;
            lat = c_id + c_ts + 1;
        end else begin
            exp_fail = 1'b0;
            lat = c_id + c_ts + 2;
        end
        epoch++;
        if (auto_go) reset = 1'b0;
        else start = 1'b1;
        @(negedge clock);
        #1;
        start = 1'b0;
        chk("entry_busy", 32'(busy), 32'd1);
        chk("entry_flags", 32'({done, timeout_err, id_ok, ts_ok}), 32'd0);
        chk("keep_id", id_value, m_id_val);
        chk("keep_ts", ts_value, m_ts_val);
        cyc = 1;
        stalls = 0;
        p_stall = 1'b0;
        p_addr = 1'b0;
        while (!(done === 1'b1 || timeout_err === 1'b1) && cyc < 400) begin
            chk("busy", 32'(busy), 32'(cyc < lat));
            if (p_stall) begin
                chk("hold_read", 32'(avm_read), 32'(stalls < TB_TO));
                if (stalls < TB_TO)
                    chk("hold_addr", 32'(avm_address), 32'(p_addr));
            end
            if (avm_read && avm_waitrequest) stalls++;
            else stalls = 0;
            p_stall = avm_read && avm_waitrequest;
            p_addr = avm_address;
            if (mid_start) start = (cyc == 2);
            @(negedge clock);
            #1;
            cyc++;
        end
        start = 1'b0;
        if (ok_id) m_id_val = d_id;
        if (ok_id && ok_ts) m_ts_val = d_ts;
        chk("latency", cyc, lat);
        chk("end_busy", 32'(busy), 32'd0);
        chk("done", 32'(done), 32'(!exp_fail));
        chk("timeout_err", 32'(timeout_err), 32'(exp_fail));
        chk("id_ok", 32'(id_ok), 32'(!exp_fail && d_id == TB_EXP_ID));
        chk("ts_ok", 32'(ts_ok), 32'(!exp_fail && d_ts == TB_EXP_TS));
        chk("id_value", id_value, m_id_val);
        chk("ts_value", ts_value, m_ts_val);
        repeat (3) @(negedge clock);
        #1;
        chk("hold_end", 32'({done, timeout_err, busy}),
            32'({!exp_fail, exp_fail, 1'b0}));
    endtask

    task automatic reset_mid_ts();
        int n;
        n = 0;
        plan_id = '{0, 0, 0};
        plan_ts = '{8, 0, 0};
        d_id = $urandom;
        d_ts = $urandom;
        epoch++;
        start = 1'b1;
        @(negedge clock);
        #1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (avm_read && avm_address && avm_waitrequest) n++;
            if (n == 2) break;
            @(negedge clock);
            #1;
        end
        chk("ts_stall2", n, 2);
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("rst_ctl", 32'({avm_read, avm_address, busy, done,
                            id_ok, ts_ok, timeout_err}), 32'd0);
        chk("rst_id", id_value, 32'd0);
        chk("rst_ts", ts_value, 32'd0);
        m_id_val = '0;
        m_ts_val = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cycles exhausted");
        $fatal(1, "watchdog expired");
    end

    initial begin
        plan_id = '{0, 0, 0};
        plan_ts = '{0, 0, 0};
        repeat (3) @(negedge clock);
        #1;
        chk("reset_ctl", 32'({avm_read, avm_address, busy, done,
                              id_ok, ts_ok, timeout_err}), 32'd0);
        chk("reset_id", id_value, 32'd0);
        chk("reset_ts", ts_value, 32'd0);

        d_id = 32'd0;
        d_ts = TB_EXP_TS;
        run_check(1'b1, 1'b0);

        d_ts = 32'd1486859882;
        run_check(1'b0, 1'b0);

        d_ts = TB_EXP_TS;
        plan_ts = '{5, 0, 0};
        run_check(1'b0, 1'b0);

        plan_id = '{20, 20, 20};
        plan_ts = '{0, 0, 0};
        d_id = $urandom;
        run_check(1'b0, 1'b0);

        plan_id = '{16, 15, 0};
        plan_ts = '{15, 16, 3};
        d_id = TB_EXP_ID;
        run_check(1'b0, 1'b0);

        plan_id = '{3, 0, 0};
        plan_ts = '{0, 0, 0};
        run_check(1'b0, 1'b1);
        d_id = 32'h1234_5678;
        d_ts = $urandom;
        run_check(1'b0, 1'b0);

        reset_mid_ts();
        plan_id = '{0, 0, 0};
        plan_ts = '{0, 0, 0};
        d_id = TB_EXP_ID;
        d_ts = TB_EXP_TS;
        run_check(1'b1, 1'b0);

        for (int k = 0; k < 30; k++) begin
            for (int a = 0; a <= TB_RETRIES; a++) begin
                plan_id[a] = rnd_stall();
                plan_ts[a] = rnd_stall();
            end
            d_id = ($urandom_range(0, 1) == 0) ? TB_EXP_ID : $urandom;
            d_ts = ($urandom_range(0, 1) == 0) ? TB_EXP_TS : $urandom;
            run_check(1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
